// File: rtl/mpsoc_sysinfo.sv
// System-information Avalon-MM slave: ID/timestamp/config words, 64-bit uptime with
// coherent hi/lo reads, byte-writable scratch registers and test-and-set locks.
module mpsoc_sysinfo #(
    parameter logic [31:0] SYSTEM_ID     = 32'h694BC90D,
    parameter logic [31:0] TIMESTAMP     = 32'h00000000,
    parameter int unsigned NUM_CPUS      = 4,
    parameter int unsigned SCRATCH_DEPTH = 8,
    parameter int unsigned NUM_LOCKS     = 8,
    parameter int unsigned ADDR_W        = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [ADDR_W-1:0]    address,
    input  logic                 read,
    input  logic                 write,
    input  logic [31:0]          writedata,
    input  logic [3:0]           byteenable,
    output logic [31:0]          readdata,
    output logic                 readdatavalid,
    output logic [NUM_LOCKS-1:0] lock_status
);

    localparam logic [ADDR_W-1:0] A_SYSID  = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_TSTAMP = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_CONFIG = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_UP_LO  = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_UP_HI  = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(5);

    localparam logic [31:0] CONFIG_WORD = {8'h02, 3'b000, 5'(NUM_LOCKS), 4'b0000,
                                           4'(SCRATCH_DEPTH), 8'(NUM_CPUS)};

    logic [63:0]          uptime_q, uptime_d;
    logic [31:0]          shadow_q, shadow_d;
    logic [31:0]          scratch_q [SCRATCH_DEPTH];
    logic [NUM_LOCKS-1:0] lock_q, lock_d;
    logic [31:0]          readdata_q, readdata_d;
    logic                 rvalid_q;

    logic rd_en, wr_en, ctrl_wr, scratch_hit, lock_hit;

    // A simultaneous read and write is a write only.
    assign wr_en   = write;
    assign rd_en   = read & ~write;
    assign ctrl_wr = wr_en && (address == A_CTRL);

    assign scratch_hit = (address[ADDR_W-1:3] == (ADDR_W-3)'(1)) &&
                         ({1'b0, address[2:0]} < 4'(SCRATCH_DEPTH));
    assign lock_hit    = (address[ADDR_W-1:4] == (ADDR_W-4)'(1)) &&
                         ({1'b0, address[3:0]} < 5'(NUM_LOCKS));

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        readdata_d = '0;
        case (address)
            A_SYSID:  readdata_d = SYSTEM_ID;
            A_TSTAMP: readdata_d = TIMESTAMP;
            A_CONFIG: readdata_d = CONFIG_WORD;
            A_UP_LO:  readdata_d = uptime_q[31:0];
            A_UP_HI:  readdata_d = shadow_q;
            default:  ;
        endcase
        for (int i = 0; i < SCRATCH_DEPTH; i++) begin
            if (scratch_hit && address[2:0] == 3'(i)) readdata_d = scratch_q[i];
        end
        for (int i = 0; i < NUM_LOCKS; i++) begin
            if (lock_hit && address[3:0] == 4'(i)) readdata_d = {31'b0, lock_q[i]};
        end
    end

    always_comb begin
        uptime_d = (ctrl_wr && writedata[0]) ? 64'd0 : uptime_q + 64'd1;
        // The high half is frozen when the low half is read, so a lo-then-hi pair is coherent.
        shadow_d = (rd_en && address == A_UP_LO) ? uptime_q[63:32] : shadow_q;
        lock_d   = lock_q;
        if (ctrl_wr && writedata[1]) lock_d = '0;
        for (int i = 0; i < NUM_LOCKS; i++) begin
            if (lock_hit && address[3:0] == 4'(i)) begin
                if (wr_en)      lock_d[i] = 1'b0;
                else if (rd_en) lock_d[i] = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock) begin
        if (reset) begin
            uptime_q   <= '0;
            shadow_q   <= '0;
            lock_q     <= '0;
            readdata_q <= '0;
            rvalid_q   <= 1'b0;
            // NOTE: the scratch array is small and software relies on it reading 0 after reset.
            for (int i = 0; i < SCRATCH_DEPTH; i++) scratch_q[i] <= '0;
        end else begin
            uptime_q <= uptime_d;
            shadow_q <= shadow_d;
            lock_q   <= lock_d;
            rvalid_q <= rd_en;
            if (rd_en) readdata_q <= readdata_d;
            for (int i = 0; i < SCRATCH_DEPTH; i++) begin
                for (int b = 0; b < 4; b++) begin
                    if (wr_en && scratch_hit && address[2:0] == 3'(i) && byteenable[b])
                        scratch_q[i][8*b +: 8] <= writedata[8*b +: 8];
                end
            end
        end
    end

    assign readdata      = readdata_q;
    assign readdatavalid = rvalid_q;
    assign lock_status   = lock_q;

endmodule

// File: tb/tb_mpsoc_sysinfo.sv
// Scoreboard bench for mpsoc_sysinfo: a default instance plus a reduced instance
// (SCRATCH_DEPTH=4, NUM_LOCKS=2, NUM_CPUS=2) sharing the address/data bus.
module tb_mpsoc_sysinfo;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  address = '0;
    logic        read_a = 1'b0, write_a = 1'b0, read_b = 1'b0, write_b = 1'b0;
    logic [31:0] writedata = '0;
    logic [3:0]  byteenable = '0;
    logic [31:0] readdata_a, readdata_b;
    logic        rvalid_a, rvalid_b;
    logic [7:0]  lock_a;
    logic [1:0]  lock_b;

    always #5 clock = ~clock;

    mpsoc_sysinfo dut_a (
        .clock(clock), .reset(reset), .address(address), .read(read_a), .write(write_a),
        .writedata(writedata), .byteenable(byteenable), .readdata(readdata_a),
        .readdatavalid(rvalid_a), .lock_status(lock_a)
    );

    mpsoc_sysinfo #(.NUM_CPUS(2), .SCRATCH_DEPTH(4), .NUM_LOCKS(2)) dut_b (
        .clock(clock), .reset(reset), .address(address), .read(read_b), .write(write_b),
        .writedata(writedata), .byteenable(byteenable), .readdata(readdata_b),
        .readdatavalid(rvalid_b), .lock_status(lock_b)
    );

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t sb_a[$];
    exp_t sb_b[$];
    exp_t ea, eb;
    int   tcyc = 0;
    int   cyc = 0;
    int   pass_cnt = 0;
    int   check_cnt = 0;

    // cyc counts clock edges since reset was last released, i.e. the live uptime value.
    always @(posedge clock) begin
        tcyc <= tcyc + 1;
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    always @(negedge clock) begin
        if (rvalid_a) begin
            if (sb_a.size() == 0) check("a_unexpected_valid", 64'(rvalid_a), 64'd0);
            else begin
                ea = sb_a.pop_front();
                check($sformatf("a_rd_%02h_data", ea.addr), 64'(readdata_a), 64'(ea.data));
                check($sformatf("a_rd_%02h_latency", ea.addr), 64'(tcyc), 64'(ea.due));
            end
        end
        if (rvalid_b) begin
            if (sb_b.size() == 0) check("b_unexpected_valid", 64'(rvalid_b), 64'd0);
            else begin
                eb = sb_b.pop_front();
                check($sformatf("b_rd_%02h_data", eb.addr), 64'(readdata_b), 64'(eb.data));
                check($sformatf("b_rd_%02h_latency", eb.addr), 64'(tcyc), 64'(eb.due));
            end
        end
    end

    // Called just after a rising edge; leaves the bus idle just after the next one.
    task automatic rd(input bit b, input logic [4:0] a, input logic [31:0] e);
        address    = a;
        writedata  = '0;
        byteenable = '0;
        if (b) begin
            read_b = 1'b1;
            sb_b.push_back('{addr: a, data: e, due: tcyc + 1});
        end else begin
            read_a = 1'b1;
            sb_a.push_back('{addr: a, data: e, due: tcyc + 1});
        end
        @(posedge clock); #1;
        read_a = 1'b0;
        read_b = 1'b0;
    endtask

    task automatic wr(input bit b, input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        address    = a;
        writedata  = d;
        byteenable = be;
        if (b) write_b = 1'b1;
        else   write_a = 1'b1;
        @(posedge clock); #1;
        write_a = 1'b0;
        write_b = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (5) @(posedge clock);
        #1;
        reset = 1'b0;
        check("reset_readdata", 64'(readdata_a), 64'd0);
        check("reset_rvalid", 64'(rvalid_a), 64'd0);
        check("reset_locks", 64'(lock_a), 64'd0);

        // Identity words back-to-back
        rd(0, 5'h00, 32'h694BC90D);
        rd(0, 5'h01, 32'h00000000);
        rd(0, 5'h02, 32'h02080804);

        // Uptime against the bench counter
        idle(10);
        rd(0, 5'h03, 32'(cyc));
        rd(0, 5'h04, 32'h0);

        // Carry into the high half between the lo and hi reads
        force dut_a.uptime_q = 64'h0000_0000_FFFF_FFFF;
        #1;
        release dut_a.uptime_q;
        rd(0, 5'h03, 32'hFFFF_FFFF);
        rd(0, 5'h04, 32'h0);
        rd(0, 5'h03, 32'h1);
        rd(0, 5'h04, 32'h1);

        // CTRL clear: 0 on the edge after the write, then counting resumes
        wr(0, 5'h05, 32'h1, 4'hF);
        rd(0, 5'h03, 32'h0);
        rd(0, 5'h03, 32'h1);
        rd(0, 5'h04, 32'h0);
        rd(0, 5'h05, 32'h0);
        rd(0, 5'h06, 32'h0);
        rd(0, 5'h1F, 32'h0);

        // Scratch byte lanes and readdata hold
        wr(0, 5'h09, 32'hAABBCCDD, 4'b1111);
        wr(0, 5'h09, 32'h11223344, 4'b0101);
        rd(0, 5'h08, 32'h0);
        rd(0, 5'h09, 32'hAA22CC44);
        idle(3);
        check("readdata_hold", 64'(readdata_a), 64'h0AA22CC44);

        // Locks
        rd(0, 5'h12, 32'h0);
        rd(0, 5'h12, 32'h1);
        check("lock2_held", 64'(lock_a), 64'h04);
        wr(0, 5'h12, 32'h0, 4'h0);
        check("lock2_released", 64'(lock_a), 64'h00);
        rd(0, 5'h12, 32'h0);
        rd(0, 5'h17, 32'h0);
        check("lock2_7_held", 64'(lock_a), 64'h84);
        rd(0, 5'h18, 32'h0);
        wr(0, 5'h05, 32'h2, 4'hF);
        check("ctrl_release_all", 64'(lock_a), 64'h00);

        // Read and write together: write only, no readdatavalid
        address = 5'h10;
        read_a  = 1'b1;
        write_a = 1'b1;
        @(posedge clock); #1;
        read_a  = 1'b0;
        write_a = 1'b0;
        check("rw_lock0_clear", 64'(lock_a[0]), 64'd0);
        rd(0, 5'h10, 32'h0);
        check("lock0_acquired", 64'(lock_a), 64'h01);

        // Reduced instance: config word and out-of-range slots
        rd(1, 5'h02, 32'h02020402);
        wr(1, 5'h0B, 32'h12345678, 4'hF);
        rd(1, 5'h0B, 32'h12345678);
        wr(1, 5'h0F, 32'hDEADBEEF, 4'hF);
        rd(1, 5'h0F, 32'h0);
        rd(1, 5'h12, 32'h0);
        rd(1, 5'h12, 32'h0);
        check("b_unmapped_lock", 64'(lock_b), 64'd0);
        rd(1, 5'h11, 32'h0);
        check("b_lock1_held", 64'(lock_b), 64'h2);
        rd(1, 5'h11, 32'h1);

        // Reset in the cycle after a read, with another read presented during reset
        rd(0, 5'h00, 32'h694BC90D);
        reset   = 1'b1;
        read_a  = 1'b1;
        address = 5'h00;
        @(posedge clock); #1;
        read_a = 1'b0;
        check("rst_rvalid", 64'(rvalid_a), 64'd0);
        check("rst_readdata", 64'(readdata_a), 64'd0);
        check("rst_locks", 64'(lock_a), 64'd0);
        reset = 1'b0;
        rd(0, 5'h09, 32'h0);
        idle(2);
        rd(0, 5'h03, 32'(cyc));

        idle(3);
        check("sb_a_empty", 64'(sb_a.size()), 64'd0);
        check("sb_b_empty", 64'(sb_b.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
